// File: rtl/alu_result_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_bcd_pkg
// Brief    : Shared widths, FSM encodings and BCD correction constants
// Revision : 1.0 - initial release
// ============================================================================
package alu_result_bcd_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int DIGITS_DEF = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] C_BCD_THRESH = 4'd5;
  localparam logic [3:0] C_BCD_ADD    = 4'd3;

endpackage
`default_nettype wire

// File: rtl/alu_result_bcd_add3_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_add3_digit
// Brief    : Double-dabble digit correction, adds 3 when the digit is >= 5
// Revision : 1.0 - initial release
// ============================================================================
module bcd_add3_digit
  import alu_result_bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= C_BCD_THRESH) ? (digit_in + C_BCD_ADD) : digit_in;

endmodule
`default_nettype wire

// File: rtl/alu_result_bcd.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_bcd
// Brief    : Signed ALU result to sign + packed BCD, one bit per clock
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_bcd
  import alu_result_bcd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_ovf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  out_err,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_mag;
  logic [BCD_W-1:0]  r_bcd;
  logic [BCD_W-1:0]  w_bcd_corr;
  logic [BCD_W-1:0]  w_bcd_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg;
  logic              w_accept;
  logic              w_last;

  assign w_accept    = in_valid && in_ready;
  assign w_last      = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_bcd_shift = {w_bcd_corr[BCD_W-2:0], r_mag[DATA_W-1]};

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_add3_digit u_add3 (
        .digit_in  (r_bcd[4*gi +: 4]),
        .digit_out (w_bcd_corr[4*gi +: 4])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = in_ovf ? DONE : SHIFT;
      SHIFT:   if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    busy      = (r_state == SHIFT);
    out_valid = (r_state == DONE);
  end

  // Result registers only load on the edge that enters DONE, so they hold through backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      out_bcd <= '0;
      out_neg <= 1'b0;
      out_err <= 1'b0;
    end else if (r_state == IDLE && w_accept) begin
      if (in_ovf) begin
        out_bcd <= '0;
        out_neg <= 1'b0;
        out_err <= 1'b1;
      end else begin
        r_neg <= in_data[DATA_W-1];
        r_mag <= in_data[DATA_W-1] ? (~in_data + DATA_W'(1)) : in_data;
        r_bcd <= '0;
        r_cnt <= '0;
      end
    end else if (r_state == SHIFT) begin
      r_bcd <= w_bcd_shift;
      r_mag <= r_mag << 1;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        out_bcd <= w_bcd_shift;
        out_neg <= r_neg;
        out_err <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_bcd.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_bcd
// Brief    : Randomised + directed bench against a decimal-arithmetic model
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_bcd;

  localparam int DATA_W = 12;
  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_data = '0;
  logic        in_ovf = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_bcd;
  logic        out_neg;
  logic        out_err;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic rand_mode = 1'b0;
  logic rdy_force = 1'b0;

  typedef struct {
    logic [15:0] bcd;
    logic        neg;
    logic        err;
    int          due;
  } exp_t;
  exp_t q[$];

  alu_result_bcd #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ovf    (in_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_neg   (out_neg),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Decimal digits of |value| by repeated division.
  function automatic logic [15:0] bcd_of(input logic [11:0] d);
    int v;
    logic [15:0] r;
    v = int'($signed(d));
    if (v < 0) v = -v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    out_ready = rand_mode ? 1'($urandom % 2) : rdy_force;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_t e;
        e.bcd = in_ovf ? 16'h0 : bcd_of(in_data);
        e.neg = in_ovf ? 1'b0 : in_data[11];
        e.err = in_ovf;
        e.due = cyc + 1 + (in_ovf ? 0 : DATA_W);
        q.push_back(e);
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic pend, ev, eb;
      pend = (q.size() > 0);
      ev = 1'b0;
      eb = 1'b0;
      if (pend) begin
        ev = (cyc >= q[0].due);
        eb = !q[0].err && (cyc < q[0].due);
      end
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(eb));
      chk("in_ready", 32'(in_ready), 32'(!pend));
      if (pend && ev && out_valid) begin
        chk("out_bcd", 32'(out_bcd), 32'(q[0].bcd));
        chk("out_neg", 32'(out_neg), 32'(q[0].neg));
        chk("out_err", 32'(out_err), 32'(q[0].err));
      end
    end
  end

  task automatic send(input logic [11:0] d, input logic ovf);
    logic acc;
    acc = 1'b0;
    in_data = d;
    in_ovf = ovf;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) chk("valid_timeout", 32'(seen), 32'd1);
  endtask

  task automatic expect_out(input string nm, input logic [15:0] b, input logic n, input logic e);
    wait_valid();
    chk({nm, "_bcd"}, 32'(out_bcd), 32'(b));
    chk({nm, "_neg"}, 32'(out_neg), 32'(n));
    chk({nm, "_err"}, 32'(out_err), 32'(e));
    @(negedge clk);
  endtask

  logic [11:0] ex_d [4] = '{12'h800, 12'h7FF, 12'h000, 12'hFFF};
  logic [15:0] ex_b [4] = '{16'h2048, 16'h2047, 16'h0000, 16'h0001};
  logic        ex_n [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    chk("model_07B", 32'(bcd_of(12'h07B)), 32'h0123);
    chk("model_F85", 32'(bcd_of(12'hF85)), 32'h0123);
    chk("model_800", 32'(bcd_of(12'h800)), 32'h2048);
    chk("model_FFF", 32'(bcd_of(12'hFFF)), 32'h0001);

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_bcd", 32'(out_bcd), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    rdy_force = 1'b1;
    send(12'h07B, 1'b0);
    expect_out("pos123", 16'h0123, 1'b0, 1'b0);
    send(12'hF85, 1'b0);
    expect_out("neg123", 16'h0123, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(ex_d[i], 1'b0);
      expect_out("extreme", ex_b[i], ex_n[i], 1'b0);
    end
    send(12'h03A, 1'b1);
    expect_out("ovf", 16'h0000, 1'b0, 1'b1);

    // Backpressure: a held result must not move and new requests must wait.
    rdy_force = 1'b0;
    send(12'h064, 1'b0);
    wait_valid();
    in_data = 12'h111;
    in_ovf = 1'b0;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_bcd", 32'(out_bcd), 32'h0100);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    rdy_force = 1'b1;
    @(negedge clk);
    rdy_force = 1'b0;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_busy", 32'(busy), 32'd1);
    rdy_force = 1'b1;
    expect_out("bp_next", 16'h0273, 1'b0, 1'b0);

    // Reset in the middle of a conversion.
    send(12'h7FF, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_bcd", 32'(out_bcd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    send(12'h7FF, 1'b0);
    expect_out("after_rst", 16'h2047, 1'b0, 1'b0);

    rand_mode = 1'b1;
    for (int n = 0; n < 150; n++) begin
      send(12'($urandom), ($urandom % 8) == 0);
      repeat ($urandom % 3) @(negedge clk);
    end
    rand_mode = 1'b0;
    rdy_force = 1'b1;
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
